// File: rtl/shift_pkg.sv
// Shared definitions for the shift register datapath and its sequencing controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package shift_pkg;

  // Controller state encodings; the numeric values are relied on by other benches.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Width of a bit-count field able to hold 0..width inclusive.
  function automatic int cw_of(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/shift_ctrl_if.sv
// Bundle of word handshake, serial output and shift-register control signals for shift_ctrl.
// Latency: n/a (wiring only).
// Backpressure: data_valid/data_ready handshake; the word is taken when both are high.
// master: the parent side (word producer plus the shift register's out bus).
// slave : the controller.
interface shift_ctrl_if #(
  parameter int WIDTH = 8
);
  import shift_pkg::*;

  localparam int CW = cw_of(WIDTH);

  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic [CW-1:0]    nbits;
  logic             abort;
  logic [WIDTH-1:0] sr_out;
  logic [WIDTH-1:0] sr_in;
  logic             sr_in_enable;
  logic             sr_shift_enable;
  logic             bit_out;
  logic             bit_valid;
  logic             busy;
  logic             done;

  modport master (
    output data_in, data_valid, nbits, abort, sr_out,
    input  data_ready, sr_in, sr_in_enable, sr_shift_enable,
           bit_out, bit_valid, busy, done
  );

  modport slave (
    input  data_in, data_valid, nbits, abort, sr_out,
    output data_ready, sr_in, sr_in_enable, sr_shift_enable,
           bit_out, bit_valid, busy, done
  );

endinterface

// File: rtl/shift_tick.sv
// Bit-period counter: counts 0..BIT_CYCLES-1 while enabled and flags the last cycle of each period.
// Latency: tick is combinational from the registered count and en.
// Backpressure: none; clr has priority over en.
// Ports: clk, rst (async active-low), clr (restart period), en (count), tick (period end).
module shift_tick #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CCW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CCW-1:0] LAST = CCW'(BIT_CYCLES - 1);

  logic [CCW-1:0] ccnt;

  assign tick = en && (ccnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ccnt <= '0;
    end else if (clr) begin
      ccnt <= '0;
    end else if (en) begin
      // Wrap on the period's last cycle so the next bit starts at zero.
      ccnt <= tick ? '0 : ccnt + CCW'(1);
    end
  end

endmodule

// File: rtl/shift_ctrl.sv
// Sequencer for an external load/shift-right register: accept a word, load it, emit len bits LSB first.
// Latency: load in the cycle after accept, then len*BIT_CYCLES shift cycles, one done cycle.
// Backpressure: data_ready is high only in IDLE; abort returns to IDLE on the next edge.
// Ports: clk, rst (async active-low), bus (shift_ctrl_if slave: word in, sr_* control, serial out, status).
module shift_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  shift_ctrl_if.slave  bus
);

  localparam int CW = cw_of(WIDTH);
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    len;
  logic [CW-1:0]    bcnt;
  logic [WIDTH-1:0] sr_in_q;
  logic             ready_q;
  logic             load_q;
  logic             bit_valid_q;
  logic             busy_q;
  logic             done_q;
  logic             accept;
  logic             tick;
  logic             last_bit;
  logic             tick_clr;
  logic             tick_en;

  // A zero or oversized request means a full word.
  function automatic logic [CW-1:0] clamp_len(input logic [CW-1:0] n);
    return ((n == '0) || (n > WIDTH_C)) ? WIDTH_C : n;
  endfunction

  assign accept   = (state == ST_IDLE) && bus.data_valid && ready_q;
  assign tick_clr = (state == ST_LOAD);
  assign tick_en  = (state == ST_SHIFT);
  assign last_bit = tick && (bcnt == (len - CW'(1)));

  shift_tick #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .en   (tick_en),
    .tick (tick)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (bus.abort && (state != ST_IDLE)) state_nxt = ST_IDLE;
  end

  // Status/strobe outputs are decoded from the next state so they are registered
  // yet line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      ready_q     <= 1'b0;
      load_q      <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sr_in_q     <= '0;
      len         <= '0;
      bcnt        <= '0;
    end else begin
      state       <= state_nxt;
      ready_q     <= (state_nxt == ST_IDLE);
      load_q      <= (state_nxt == ST_LOAD);
      bit_valid_q <= (state_nxt == ST_SHIFT);
      busy_q      <= (state_nxt != ST_IDLE);
      done_q      <= (state_nxt == ST_DONE);
      if (accept) begin
        sr_in_q <= bus.data_in;
        len     <= clamp_len(bus.nbits);
      end
      if (state == ST_LOAD) begin
        bcnt <= '0;
      end else if (tick) begin
        bcnt <= bcnt + CW'(1);
      end
    end
  end

  assign bus.data_ready      = ready_q;
  assign bus.sr_in           = sr_in_q;
  assign bus.sr_in_enable    = load_q;
  assign bus.sr_shift_enable = tick;
  assign bus.bit_out         = bus.sr_out[0];
  assign bus.bit_valid       = bit_valid_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Bench for shift_ctrl with BIT_CYCLES=1 and BIT_CYCLES=3 instances, each driving a behavioural shift register.
// Latency: n/a.
// Backpressure: n/a.
module tb_shift_ctrl;
  import shift_pkg::*;

  localparam int WIDTH = 8;
  localparam int CW    = cw_of(WIDTH);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  shift_ctrl_if #(.WIDTH(WIDTH)) if1 ();
  shift_ctrl_if #(.WIDTH(WIDTH)) if3 ();

  shift_ctrl #(.WIDTH(WIDTH), .BIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  shift_ctrl #(.WIDTH(WIDTH), .BIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

  // Shared stimulus, steered to one instance by sel.
  logic             sel  = 1'b0;
  logic [WIDTH-1:0] d_in = '0;
  logic [CW-1:0]    nb   = '0;
  logic             dv   = 1'b0;
  logic             ab   = 1'b0;

  assign if1.data_in    = d_in;
  assign if3.data_in    = d_in;
  assign if1.nbits      = nb;
  assign if3.nbits      = nb;
  assign if1.data_valid = dv && !sel;
  assign if3.data_valid = dv && sel;
  assign if1.abort      = ab && !sel;
  assign if3.abort      = ab && sel;

  // Load-priority, shift-right register as the parent would provide.
  logic [WIDTH-1:0] sr1 = '0;
  logic [WIDTH-1:0] sr3 = '0;
  always @(posedge clk) begin
    if (if1.sr_in_enable) sr1 <= if1.sr_in;
    else if (if1.sr_shift_enable) sr1 <= sr1 >> 1;
    if (if3.sr_in_enable) sr3 <= if3.sr_in;
    else if (if3.sr_shift_enable) sr3 <= sr3 >> 1;
  end
  assign if1.sr_out = sr1;
  assign if3.sr_out = sr3;

  logic             o_ready, o_load, o_shift, o_bit, o_bval, o_busy, o_done;
  logic [WIDTH-1:0] o_sr_in;
  assign o_ready = sel ? if3.data_ready      : if1.data_ready;
  assign o_load  = sel ? if3.sr_in_enable    : if1.sr_in_enable;
  assign o_shift = sel ? if3.sr_shift_enable : if1.sr_shift_enable;
  assign o_bit   = sel ? if3.bit_out         : if1.bit_out;
  assign o_bval  = sel ? if3.bit_valid       : if1.bit_valid;
  assign o_busy  = sel ? if3.busy            : if1.busy;
  assign o_done  = sel ? if3.done            : if1.done;
  assign o_sr_in = sel ? if3.sr_in           : if1.sr_in;

  int overlap = 0;
  always @(negedge clk) begin
    if ((if1.sr_in_enable && if1.sr_shift_enable) || (if3.sr_in_enable && if3.sr_shift_enable))
      overlap++;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model state: the word in flight, its clamped length, and cycles per bit.
  logic [WIDTH-1:0] exp_word;
  int               exp_len;
  int               bc;

  function automatic int clamp(input int n);
    return (n == 0 || n > WIDTH) ? WIDTH : n;
  endfunction

  // Present a word at a falling edge and wait (bounded) until it will be taken on the next rising edge.
  task automatic accept_word(input bit s, input logic [WIDTH-1:0] d, input int n);
    int guard;
    guard    = 0;
    sel      = s;
    bc       = s ? 3 : 1;
    d_in     = d;
    nb       = CW'(n);
    dv       = 1'b1;
    exp_word = d;
    exp_len  = clamp(n);
    while (!o_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!o_ready) chk("accept_wait", 32'(o_ready), 32'd1);
  endtask

  // Follow one transaction cycle by cycle from the accept edge (cycle 0) and compare against the
  // timeline: cycle 0 load, cycles 1..L shift, L+1 done, L+2 ready again (L = len*bc).
  task automatic walk(input int abort_at, input bit keep, input logic [WIDTH-1:0] nd, input int nn);
    int L;
    int shifts;
    bit in_load, in_shift, in_done, in_idle;
    L      = exp_len * bc;
    shifts = 0;
    @(posedge clk);
    #1;
    d_in = keep ? nd : WIDTH'($urandom);
    nb   = keep ? CW'(nn) : CW'($urandom);
    dv   = keep;
    for (int c = 0; c <= L + 2; c++) begin
      @(negedge clk);
      in_load  = (c == 0);
      in_shift = (c >= 1) && (c <= L);
      in_done  = (c == L + 1);
      in_idle  = (c == L + 2);
      chk($sformatf("load c%0d", c),   32'(o_load),  32'(in_load));
      chk($sformatf("bval c%0d", c),   32'(o_bval),  32'(in_shift));
      chk($sformatf("shift c%0d", c),  32'(o_shift), 32'(in_shift && (c % bc == 0)));
      chk($sformatf("done c%0d", c),   32'(o_done),  32'(in_done));
      chk($sformatf("ready c%0d", c),  32'(o_ready), 32'(in_idle));
      chk($sformatf("busy c%0d", c),   32'(o_busy),  32'(!in_idle));
      if (in_load) chk("sr_in", 32'(o_sr_in), 32'(exp_word));
      if (in_shift) chk($sformatf("bit c%0d", c), 32'(o_bit), 32'((exp_word >> ((c - 1) / bc)) & 1));
      if (o_shift) shifts++;
      if (c == abort_at) begin
        ab = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          ab = 1'b0;
          chk("abort_ready", 32'(o_ready), 32'd1);
          chk("abort_busy",  32'(o_busy),  32'd0);
          chk("abort_shift", 32'(o_shift), 32'd0);
          chk("abort_load",  32'(o_load),  32'd0);
          chk("abort_done",  32'(o_done),  32'd0);
        end
        return;
      end
    end
    chk("shift_count", 32'(shifts), 32'(exp_len));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset state, including the registered data_ready rising one edge after release.
    repeat (2) @(negedge clk);
    chk("rst_ready1", 32'(if1.data_ready), 32'd0);
    chk("rst_ready3", 32'(if3.data_ready), 32'd0);
    chk("rst_busy1",  32'(if1.busy),       32'd0);
    chk("rst_bval1",  32'(if1.bit_valid),  32'd0);
    chk("rst_sr_in1", 32'(if1.sr_in),      32'd0);
    rst = 1'b1;
    #1;
    chk("rel_ready_before_edge", 32'(if1.data_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rel_ready_after_edge1", 32'(if1.data_ready), 32'd1);
    chk("rel_ready_after_edge3", 32'(if3.data_ready), 32'd1);
    @(negedge clk);

    // Full word, nbits=0 means all 8 bits.
    accept_word(1'b0, 8'h1A, 0);
    walk(-1, 1'b0, '0, 0);
    // Three bits, three cycles per bit.
    accept_word(1'b1, 8'h05, 3);
    walk(-1, 1'b0, '0, 0);
    // Oversized nbits clamps to the word width.
    accept_word(1'b0, 8'hFF, 12);
    walk(-1, 1'b0, '0, 0);
    // Abort in the third SHIFT cycle, then a fresh word goes through normally.
    accept_word(1'b0, 8'hA5, 0);
    walk(3, 1'b0, '0, 0);
    accept_word(1'b0, 8'h3C, 5);
    walk(-1, 1'b0, '0, 0);

    // Asynchronous reset in the middle of shifting.
    accept_word(1'b1, 8'h96, 0);
    @(posedge clk);
    #1;
    dv = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ready", 32'(o_ready), 32'd0);
    chk("midrst_busy",  32'(o_busy),  32'd0);
    chk("midrst_bval",  32'(o_bval),  32'd0);
    chk("midrst_shift", 32'(o_shift), 32'd0);
    chk("midrst_load",  32'(o_load),  32'd0);
    chk("midrst_done",  32'(o_done),  32'd0);
    chk("midrst_sr_in", 32'(o_sr_in), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ready_rel", 32'(o_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_ready_edge", 32'(o_ready), 32'd1);
    chk("midrst_no_done",    32'(o_done),  32'd0);
    @(negedge clk);

    // data_valid held across two words: second accept only once ready returns.
    accept_word(1'b0, 8'h81, 0);
    walk(-1, 1'b1, 8'h3C, 0);
    accept_word(1'b0, 8'h3C, 0);
    walk(-1, 1'b0, '0, 0);

    // Randomized words, lengths, instances and occasional aborts.
    for (int i = 0; i < 30; i++) begin
      bit          s;
      int          n;
      int          a;
      logic [WIDTH-1:0] d;
      s = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 15);
      d = WIDTH'($urandom);
      a = -1;
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, clamp(n) * (s ? 3 : 1) + 1);
      accept_word(s, d, n);
      walk(a, 1'b0, '0, 0);
    end

    chk("strobe_overlap", 32'(overlap), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
